// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master FSM: serialises address/R-W and data onto open-drain SDA, paced by data_clk.
// Optional build macro I2C_NACK_ABORT_EN: a slave NACK forces STOP on the next data_clk rise.
module i2c_master_byte_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_clk_i,
    input  logic              ena_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              rw_i,
    input  logic [DATA_W-1:0] data_wr_i,
    input  logic              sda_in_i,
    output logic              sda_oe_o,
    output logic              scl_not_ena_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] data_rd_o,
    output logic              ack_error_o
);
    // addr_rw shares bit_cnt with data bytes, so ADDR_W+1 is expected to equal DATA_W.
    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [3:0] {
        READY    = 4'd0,
        START    = 4'd1,
        COMMAND  = 4'd2,
        SLV_ACK1 = 4'd3,
        WR       = 4'd4,
        RD       = 4'd5,
        SLV_ACK2 = 4'd6,
        MSTR_ACK = 4'd7,
        STOP     = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [ADDR_W:0]     addr_rw_q, addr_rw_d;
    logic [DATA_W-1:0]   data_tx_q, data_tx_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   data_rd_q, data_rd_d;
    logic                sda_int_q, sda_int_d;
    logic                busy_q, busy_d;
    logic                scl_not_ena_q, scl_not_ena_d;
    logic                ack_error_q, ack_error_d;
    logic                sda_oe_q, sda_oe_d;
    logic                data_clk_q;

    logic                rise_s, fall_s, same_cmd_s, abort_s;
    logic [ADDR_W:0]     cmd_s;
    logic [CNT_W-1:0]    bit_dec_s;

    assign rise_s     = data_clk_i & ~data_clk_q;
    assign fall_s     = ~data_clk_i & data_clk_q;
    assign cmd_s      = {addr_i, rw_i};
    assign same_cmd_s = (cmd_s == addr_rw_q);
    assign bit_dec_s  = bit_cnt_q - CNT_ONE;

`ifdef I2C_NACK_ABORT_EN
    // A NACK is only recorded in ack slots and any earlier one would already have aborted.
    assign abort_s = ack_error_q;
`else
    assign abort_s = 1'b0;
`endif

    // Next-state logic: rises advance the bit/byte sequence, falls sample the bus.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        addr_rw_d     = addr_rw_q;
        data_tx_d     = data_tx_q;
        rx_shift_d    = rx_shift_q;
        data_rd_d     = data_rd_q;
        sda_int_d     = sda_int_q;
        busy_d        = busy_q;
        scl_not_ena_d = scl_not_ena_q;
        ack_error_d   = ack_error_q;
        if (rise_s) begin
            case (state_q)
                READY: begin
                    if (ena_i) begin
                        busy_d    = 1'b1;
                        addr_rw_d = cmd_s;
                        data_tx_d = data_wr_i;
                        state_d   = START;
                    end else begin
                        busy_d    = 1'b0;
                    end
                end
                START: begin
                    busy_d    = 1'b1;
                    sda_int_d = addr_rw_q[bit_cnt_q];
                    state_d   = COMMAND;
                end
                COMMAND: begin
                    if (bit_cnt_q == CNT_ZERO) begin
                        sda_int_d = 1'b1;
                        bit_cnt_d = CNT_MAX;
                        state_d   = SLV_ACK1;
                    end else begin
                        bit_cnt_d = bit_dec_s;
                        sda_int_d = addr_rw_q[bit_dec_s];
                    end
                end
                SLV_ACK1: begin
                    if (abort_s) begin
                        sda_int_d = 1'b1;
                        state_d   = STOP;
                    end else if (addr_rw_q[0] == 1'b0) begin
                        sda_int_d = data_tx_q[bit_cnt_q];
                        state_d   = WR;
                    end else begin
                        sda_int_d = 1'b1;
                        state_d   = RD;
                    end
                end
                WR: begin
                    busy_d = 1'b1;
                    if (bit_cnt_q == CNT_ZERO) begin
                        sda_int_d = 1'b1;
                        bit_cnt_d = CNT_MAX;
                        state_d   = SLV_ACK2;
                    end else begin
                        bit_cnt_d = bit_dec_s;
                        sda_int_d = data_tx_q[bit_dec_s];
                    end
                end
                RD: begin
                    busy_d = 1'b1;
                    if (bit_cnt_q == CNT_ZERO) begin
                        // ACK only when the user is continuing with an identical read command.
                        sda_int_d = ~(ena_i & same_cmd_s);
                        bit_cnt_d = CNT_MAX;
                        data_rd_d = rx_shift_q;
                        state_d   = MSTR_ACK;
                    end else begin
                        bit_cnt_d = bit_dec_s;
                    end
                end
                SLV_ACK2: begin
                    if (abort_s) begin
                        sda_int_d = 1'b1;
                        state_d   = STOP;
                    end else if (ena_i) begin
                        busy_d    = 1'b0;
                        addr_rw_d = cmd_s;
                        data_tx_d = data_wr_i;
                        if (same_cmd_s) begin
                            sda_int_d = data_wr_i[bit_cnt_q];
                            state_d   = WR;
                        end else begin
                            sda_int_d = 1'b1;
                            state_d   = START;
                        end
                    end else begin
                        sda_int_d = 1'b1;
                        state_d   = STOP;
                    end
                end
                MSTR_ACK: begin
                    sda_int_d = 1'b1;
                    if (ena_i) begin
                        busy_d    = 1'b0;
                        addr_rw_d = cmd_s;
                        data_tx_d = data_wr_i;
                        if (same_cmd_s) begin
                            state_d = RD;
                        end else begin
                            state_d = START;
                        end
                    end else begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    busy_d    = 1'b0;
                    sda_int_d = 1'b1;
                    state_d   = READY;
                end
                default: begin
                    busy_d    = 1'b0;
                    sda_int_d = 1'b1;
                    state_d   = READY;
                end
            endcase
        end else if (fall_s) begin
            case (state_q)
                START: begin
                    scl_not_ena_d = 1'b0;
                    ack_error_d   = 1'b0;
                end
                SLV_ACK1, SLV_ACK2: begin
                    if (sda_in_i) begin
                        ack_error_d = 1'b1;
                    end else begin
                        ack_error_d = ack_error_q;
                    end
                end
                RD: begin
                    rx_shift_d[bit_cnt_q] = sda_in_i;
                end
                STOP: begin
                    scl_not_ena_d = 1'b1;
                end
                default: begin
                    scl_not_ena_d = scl_not_ena_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // SDA is forced low for the whole START and STOP slots; otherwise it follows the serial bit.
    always_comb begin
        if ((state_d == START) || (state_d == STOP)) begin
            sda_oe_d = 1'b1;
        end else begin
            sda_oe_d = ~sda_int_d;
        end
    end

    // State and output registers; reset releases both bus lines immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= READY;
            bit_cnt_q     <= CNT_MAX;
            addr_rw_q     <= '0;
            data_tx_q     <= '0;
            rx_shift_q    <= '0;
            data_rd_q     <= '0;
            sda_int_q     <= 1'b1;
            busy_q        <= 1'b0;
            scl_not_ena_q <= 1'b1;
            ack_error_q   <= 1'b0;
            sda_oe_q      <= 1'b0;
            data_clk_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            addr_rw_q     <= addr_rw_d;
            data_tx_q     <= data_tx_d;
            rx_shift_q    <= rx_shift_d;
            data_rd_q     <= data_rd_d;
            sda_int_q     <= sda_int_d;
            busy_q        <= busy_d;
            scl_not_ena_q <= scl_not_ena_d;
            ack_error_q   <= ack_error_d;
            sda_oe_q      <= sda_oe_d;
            data_clk_q    <= data_clk_i;
        end
    end

    assign sda_oe_o      = sda_oe_q;
    assign scl_not_ena_o = scl_not_ena_q;
    assign busy_o        = busy_q;
    assign data_rd_o     = data_rd_q;
    assign ack_error_o   = ack_error_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: each transaction is expanded into expected per-bit SDA slots
// from the I2C framing rules, with a behavioural slave answering ACKs and read bits.
module tb_i2c_master_byte_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, data_clk, ena, rw, sda_in, sda_oe, scl_not_ena, busy, ack_error;
    logic [6:0] addr;
    logic [7:0] data_wr, data_rd;
    logic       slave_pull;

    always #5 clk = ~clk;

    // Wired-AND bus: either side pulling low wins.
    assign sda_in = ~sda_oe & ~slave_pull;

    i2c_master_byte_ctrl dut (
        .clk(clk), .rst_n(rst_n), .data_clk_i(data_clk), .ena_i(ena), .addr_i(addr),
        .rw_i(rw), .data_wr_i(data_wr), .sda_in_i(sda_in), .sda_oe_o(sda_oe),
        .scl_not_ena_o(scl_not_ena), .busy_o(busy), .data_rd_o(data_rd), .ack_error_o(ack_error)
    );

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
        logic       addr_nack;
        logic       data_nack;
    } cmd_t;

    typedef struct {
        logic oe;
        logic busy;
        logic scl;
        logic slave_low;
        logic latch;
    } slot_t;

    cmd_t       cmd_q[$];
    slot_t      plan_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_rd;
    logic       exp_ack_err;
    logic       rd_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void add_cmd(input logic [6:0] a, input logic r, input logic [7:0] d,
                                    input logic an);
        cmd_t c;
        c.addr = a; c.rw = r; c.data = d; c.addr_nack = an; c.data_nack = 1'b0;
        cmd_q.push_back(c);
    endfunction

    function automatic void push(input logic oe, input logic bz, input logic scl,
                                 input logic sl, input logic lat);
        slot_t s;
        s.oe = oe; s.busy = bz; s.scl = scl; s.slave_low = sl; s.latch = lat;
        plan_q.push_back(s);
    endfunction

    // Expand the command list into the bit slots an I2C master must produce.
    task automatic build_model();
        logic [7:0] ar, prev_ar;
        logic       bz, first, nack, ackv, stop_now;
        int         n;
        n = cmd_q.size();
        plan_q.delete();
        nack = 1'b0; rd_seen = 1'b0; prev_ar = 8'h00; stop_now = 1'b0;
        for (int i = 0; i < n && !stop_now; i++) begin
            ar    = {cmd_q[i].addr, cmd_q[i].rw};
            bz    = (i == 0);
            first = 1'b1;
            if (i == 0 || ar != prev_ar) begin
                push(1'b1, bz, 1'b0, 1'b0, first);
                first = 1'b0; bz = 1'b1; nack = 1'b0;
                for (int b = 7; b >= 0; b--) push(~ar[b], 1'b1, 1'b0, 1'b0, 1'b0);
                push(1'b0, 1'b1, 1'b0, ~cmd_q[i].addr_nack, 1'b0);
                if (cmd_q[i].addr_nack) begin
                    nack = 1'b1;
`ifdef I2C_NACK_ABORT_EN
                    stop_now = 1'b1;
`endif
                end
            end
            if (!stop_now) begin
                if (cmd_q[i].rw == 1'b0) begin
                    for (int b = 7; b >= 0; b--) begin
                        push(~cmd_q[i].data[b], bz, 1'b0, 1'b0, first);
                        bz = 1'b1; first = 1'b0;
                    end
                    push(1'b0, 1'b1, 1'b0, ~cmd_q[i].data_nack, 1'b0);
                end else begin
                    for (int b = 7; b >= 0; b--) begin
                        push(1'b0, bz, 1'b0, ~cmd_q[i].data[b], first);
                        bz = 1'b1; first = 1'b0;
                    end
                    ackv = (i + 1 < n) && ({cmd_q[i+1].addr, cmd_q[i+1].rw} == ar);
                    push(ackv, 1'b1, 1'b0, 1'b0, 1'b0);
                    exp_rd = cmd_q[i].data; rd_seen = 1'b1;
                end
            end
            prev_ar = ar;
        end
        push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_ack_err = nack;
    endtask

    task automatic apply(input int i);
        addr = cmd_q[i].addr; rw = cmd_q[i].rw; data_wr = cmd_q[i].data; ena = 1'b1;
    endtask

    // One data_clk period: rise, check driven bit, slave responds, fall, check SCL enable.
    task automatic do_slot(input slot_t s, input string name, input int k);
        data_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("%s.sda_oe[%0d]", name, k), 32'(sda_oe), 32'(s.oe));
        chk($sformatf("%s.busy[%0d]", name, k), 32'(busy), 32'(s.busy));
        slave_pull = s.slave_low;
        repeat (2) @(posedge clk);
        #1;
        data_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk($sformatf("%s.scl_not_ena[%0d]", name, k), 32'(scl_not_ena), 32'(s.scl));
    endtask

    task automatic run_txn(input string name);
        int ci;
        build_model();
        ci = 0;
        apply(0);
        for (int k = 0; k < plan_q.size(); k++) begin
            do_slot(plan_q[k], name, k);
            if (plan_q[k].latch) begin
                ci++;
                if (ci < cmd_q.size()) apply(ci);
                else ena = 1'b0;
            end
        end
        slave_pull = 1'b0;
        chk({name, ".ack_error"}, 32'(ack_error), 32'(exp_ack_err));
        if (rd_seen) chk({name, ".data_rd"}, 32'(data_rd), 32'(exp_rd));
        chk({name, ".end_busy"}, 32'(busy), 32'd0);
        chk({name, ".end_scl"}, 32'(scl_not_ena), 32'd1);
    endtask

    initial begin
        slot_t idle;
        int    nc;
        rst_n = 1'b0; data_clk = 1'b0; ena = 1'b0; addr = 7'h00; rw = 1'b0;
        data_wr = 8'h00; slave_pull = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.sda_oe", 32'(sda_oe), 32'd0);
        chk("rst.scl_not_ena", 32'(scl_not_ena), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.data_rd", 32'(data_rd), 32'd0);
        chk("rst.ack_error", 32'(ack_error), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        idle.oe = 1'b0; idle.busy = 1'b0; idle.scl = 1'b1; idle.slave_low = 1'b0; idle.latch = 1'b0;
        for (int k = 0; k < 3; k++) do_slot(idle, "idle", k);

        cmd_q.delete(); add_cmd(7'h50, 1'b0, 8'hA5, 1'b0); run_txn("t1_write");
        cmd_q.delete(); add_cmd(7'h3C, 1'b1, 8'h5A, 1'b0); run_txn("t2_read");
        cmd_q.delete(); add_cmd(7'h50, 1'b0, 8'h11, 1'b0); add_cmd(7'h50, 1'b1, 8'hC3, 1'b0);
        run_txn("t3_rstart");
        cmd_q.delete(); add_cmd(7'h2A, 1'b0, 8'h01, 1'b0); add_cmd(7'h2A, 1'b0, 8'hFE, 1'b0);
        add_cmd(7'h2A, 1'b0, 8'h80, 1'b0); run_txn("t3_multi_wr");
        cmd_q.delete(); add_cmd(7'h61, 1'b1, 8'h96, 1'b0); add_cmd(7'h61, 1'b1, 8'h0F, 1'b0);
        run_txn("t3_multi_rd");
        cmd_q.delete(); add_cmd(7'h7F, 1'b0, 8'h3C, 1'b1); run_txn("t4_addr_nack");
        cmd_q.delete(); add_cmd(7'h12, 1'b0, 8'h77, 1'b0); run_txn("t4_recover");

        for (int t = 0; t < 8; t++) begin
            cmd_q.delete();
            nc = $urandom_range(1, 3);
            for (int j = 0; j < nc; j++)
                add_cmd(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 255)), 1'b0);
            run_txn($sformatf("rand%0d", t));
        end

        // Reset in the middle of the write byte, bit 4 (data 0xE0 drives bit 4 low).
        cmd_q.delete(); add_cmd(7'h55, 1'b0, 8'hE0, 1'b0);
        build_model();
        apply(0);
        for (int k = 0; k < 13; k++) begin
            do_slot(plan_q[k], "t5", k);
            if (plan_q[k].latch) ena = 1'b0;
        end
        data_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t5.pre_sda_oe", 32'(sda_oe), 32'(plan_q[13].oe));
        chk("t5.pre_busy", 32'(busy), 32'd1);
        chk("t5.pre_scl", 32'(scl_not_ena), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t5.rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("t5.rst_scl", 32'(scl_not_ena), 32'd1);
        chk("t5.rst_busy", 32'(busy), 32'd0);
        chk("t5.rst_data_rd", 32'(data_rd), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        data_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t5.post_sda_oe", 32'(sda_oe), 32'd0);
        chk("t5.post_busy", 32'(busy), 32'd0);
        cmd_q.delete(); add_cmd(7'h0A, 1'b1, 8'hB4, 1'b0); run_txn("t5_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
